// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and data_mem bus for mem_arbiter
// slave is the arbiter's view; master is the requesters' and data_mem's view.
interface mem_arbiter_if;
  logic       cpu_req;
  logic       cpu_w_en;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_w_data;
  logic [7:0] cpu_r_data;
  logic       cpu_ack;
  logic       cpu_stall;

  logic       ext_req;
  logic       ext_w_en;
  logic [7:0] ext_addr;
  logic [7:0] ext_w_data;
  logic [7:0] ext_r_data;
  logic       ext_ack;

  logic [7:0] mem_addr;
  logic [7:0] mem_w_data;
  logic       mem_w_en;
  logic [7:0] mem_r_data;

  modport slave (
    input  cpu_req, cpu_w_en, cpu_addr, cpu_w_data,
    output cpu_r_data, cpu_ack, cpu_stall,
    input  ext_req, ext_w_en, ext_addr, ext_w_data,
    output ext_r_data, ext_ack,
    output mem_addr, mem_w_data, mem_w_en,
    input  mem_r_data
  );

  modport master (
    output cpu_req, cpu_w_en, cpu_addr, cpu_w_data,
    input  cpu_r_data, cpu_ack, cpu_stall,
    output ext_req, ext_w_en, ext_addr, ext_w_data,
    input  ext_r_data, ext_ack,
    input  mem_addr, mem_w_data, mem_w_en,
    output mem_r_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing data_mem between cpu and ext
// Each access takes one GRANT and one ACK cycle.
module mem_arbiter (
  input logic   clock,
  input logic   reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT_CPU = 3'd1,
    GRANT_EXT = 3'd2,
    ACK_CPU   = 3'd3,
    ACK_EXT   = 3'd4
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  state_t     state;
  logic       last_grant;
  logic       lat_w_en;
  logic [7:0] lat_addr;
  logic [7:0] lat_w_data;
  logic [7:0] cpu_r_data_q;
  logic [7:0] ext_r_data_q;
  logic       in_grant;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= PORT_EXT;
      lat_w_en     <= 1'b0;
      lat_addr     <= 8'h00;
      lat_w_data   <= 8'h00;
      cpu_r_data_q <= 8'h00;
      ext_r_data_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the CPU wins only if EXT had the previous grant.
          if (bus.cpu_req && (!bus.ext_req || last_grant == PORT_EXT)) begin
            state      <= GRANT_CPU;
            last_grant <= PORT_CPU;
            lat_w_en   <= bus.cpu_w_en;
            lat_addr   <= bus.cpu_addr;
            lat_w_data <= bus.cpu_w_data;
          end else if (bus.ext_req) begin
            state      <= GRANT_EXT;
            last_grant <= PORT_EXT;
            lat_w_en   <= bus.ext_w_en;
            lat_addr   <= bus.ext_addr;
            lat_w_data <= bus.ext_w_data;
          end
        end
        GRANT_CPU: begin
          state <= ACK_CPU;
          if (!lat_w_en) cpu_r_data_q <= bus.mem_r_data;
        end
        GRANT_EXT: begin
          state <= ACK_EXT;
          if (!lat_w_en) ext_r_data_q <= bus.mem_r_data;
        end
        ACK_CPU, ACK_EXT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write enable follows the state register so a write in flight is still presented under reset.
  assign in_grant       = (state == GRANT_CPU) || (state == GRANT_EXT);
  assign bus.mem_w_en   = in_grant & lat_w_en;
  assign bus.mem_addr   = lat_addr;
  assign bus.mem_w_data = lat_w_data;

  assign bus.cpu_ack    = (state == ACK_CPU);
  assign bus.ext_ack    = (state == ACK_EXT);
  assign bus.cpu_r_data = cpu_r_data_q;
  assign bus.ext_r_data = ext_r_data_q;
  assign bus.cpu_stall  = bus.cpu_req & ~bus.cpu_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
// Ack monitor pops expected {port, r_data} entries in completion order.
module tb_mem_arbiter;
  logic clock;
  logic reset;
  logic mem_init;
  logic [7:0] mem [256];
  logic [8:0] sb [$];
  logic [8:0] ent;
  int n_tests;
  int n_fail;
  int ack_cnt;
  int ack_base;
  logic [7:0] exp_cpu_r;
  logic [7:0] exp_ext_r;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // data_mem model: combinational read, write on the rising edge.
  assign bus.mem_r_data = mem[bus.mem_addr];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h1C;
    end else if (bus.mem_w_en) begin
      mem[bus.mem_addr] <= bus.mem_w_data;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.cpu_ack || bus.ext_ack) begin
      ack_cnt++;
      if (sb.size() == 0) begin
        check("ack_unexpected", 8'({bus.cpu_ack, bus.ext_ack}), 8'h00);
      end else begin
        ent = sb.pop_front();
        check("ack_port", 8'({bus.cpu_ack, bus.ext_ack}), ent[8] ? 8'h01 : 8'h02);
        check("ack_r_data", ent[8] ? bus.ext_r_data : bus.cpu_r_data, ent[7:0]);
      end
    end
  end

  task automatic step;
    @(negedge clock);
  endtask

  task automatic quiet_inputs;
    bus.cpu_req = 1'b0; bus.cpu_w_en = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_w_data = 8'h00;
    bus.ext_req = 1'b0; bus.ext_w_en = 1'b0; bus.ext_addr = 8'h00; bus.ext_w_data = 8'h00;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step; step;
    reset = 1'b0;
    exp_cpu_r = 8'h00;
    exp_ext_r = 8'h00;
    step;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cpu_ack"},    8'(bus.cpu_ack), 8'h00);
    check({pfx, "_ext_ack"},    8'(bus.ext_ack), 8'h00);
    check({pfx, "_mem_w_en"},   8'(bus.mem_w_en), 8'h00);
    check({pfx, "_cpu_r_data"}, bus.cpu_r_data, 8'h00);
    check({pfx, "_ext_r_data"}, bus.ext_r_data, 8'h00);
    check({pfx, "_mem_addr"},   bus.mem_addr, 8'h00);
    check({pfx, "_mem_w_data"}, bus.mem_w_data, 8'h00);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; ack_cnt = 0;
    exp_cpu_r = 8'h00; exp_ext_r = 8'h00;
    quiet_inputs();
    reset = 1'b1;
    mem_init = 1'b1;
    step; step; step;
    mem_init = 1'b0;
    check_reset_outputs("rst");
    check("rst_cpu_stall", 8'(bus.cpu_stall), 8'h00);
    reset = 1'b0;
    step;

    // CPU write 0xA5 -> 0x10
    bus.cpu_req = 1'b1; bus.cpu_w_en = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_w_data = 8'hA5;
    sb.push_back({1'b0, exp_cpu_r});
    #1 check("wr_stall_n0", 8'(bus.cpu_stall), 8'h01);
    step;
    check("wr_mem_w_en", 8'(bus.mem_w_en), 8'h01);
    check("wr_mem_addr", bus.mem_addr, 8'h10);
    check("wr_mem_w_data", bus.mem_w_data, 8'hA5);
    check("wr_stall_n1", 8'(bus.cpu_stall), 8'h01);
    check("wr_no_early_ack", 8'(bus.cpu_ack), 8'h00);
    step;
    check("wr_ack_n2", 8'(bus.cpu_ack), 8'h01);
    check("wr_stall_n2", 8'(bus.cpu_stall), 8'h00);
    bus.cpu_req = 1'b0;
    step;
    check("wr_ack_pulse", 8'(bus.cpu_ack), 8'h00);
    check("wr_w_en_idle", 8'(bus.mem_w_en), 8'h00);
    check("wr_mem_10", mem[8'h10], 8'hA5);

    // EXT read of 0x20 (holds 0x3C)
    bus.ext_req = 1'b1; bus.ext_w_en = 1'b0; bus.ext_addr = 8'h20;
    exp_ext_r = 8'h3C;
    sb.push_back({1'b1, exp_ext_r});
    step;
    check("rd_mem_addr", bus.mem_addr, 8'h20);
    check("rd_w_en", 8'(bus.mem_w_en), 8'h00);
    check("rd_no_early_ack", 8'(bus.ext_ack), 8'h00);
    step;
    check("rd_ack_n2", 8'(bus.ext_ack), 8'h01);
    check("rd_cpu_r_hold", bus.cpu_r_data, exp_cpu_r);
    bus.ext_req = 1'b0;
    step;
    check("rd_ext_r_hold", bus.ext_r_data, 8'h3C);

    // simultaneous requests right after reset: CPU first
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_w_en = 1'b0; bus.cpu_addr = 8'h01;
    bus.ext_req = 1'b1; bus.ext_w_en = 1'b0; bus.ext_addr = 8'h02;
    exp_cpu_r = 8'h1D; exp_ext_r = 8'h1E;
    sb.push_back({1'b0, exp_cpu_r});
    sb.push_back({1'b1, exp_ext_r});
    step;
    check("tie_n1_addr", bus.mem_addr, 8'h01);
    step;
    check("tie_n2_cpu_ack", 8'(bus.cpu_ack), 8'h01);
    bus.cpu_req = 1'b0;
    step;
    check("tie_n3_ext_ack", 8'(bus.ext_ack), 8'h00);
    step;
    check("tie_n4_addr", bus.mem_addr, 8'h02);
    step;
    check("tie_n5_ext_ack", 8'(bus.ext_ack), 8'h01);
    bus.ext_req = 1'b0;
    step;

    // continuous contention for 12 cycles
    do_reset();
    ack_base = ack_cnt;
    bus.cpu_req = 1'b1; bus.cpu_w_en = 1'b0; bus.cpu_addr = 8'h30;
    bus.ext_req = 1'b1; bus.ext_w_en = 1'b0; bus.ext_addr = 8'h31;
    exp_cpu_r = 8'h2C; exp_ext_r = 8'h2D;
    for (int k = 0; k < 2; k++) begin
      sb.push_back({1'b0, exp_cpu_r});
      sb.push_back({1'b1, exp_ext_r});
    end
    for (int i = 1; i < 12; i++) begin
      step;
      if (i == 11) begin
        bus.cpu_req = 1'b0;
        bus.ext_req = 1'b0;
      end
    end
    step;
    check("rr_ack_count", 8'(ack_cnt - ack_base), 8'h04);

    // reset during GRANT_EXT of a write
    bus.ext_req = 1'b1; bus.ext_w_en = 1'b1; bus.ext_addr = 8'h40; bus.ext_w_data = 8'h99;
    step;
    check("rg_w_en_grant", 8'(bus.mem_w_en), 8'h01);
    reset = 1'b1;
    #1 check("rg_w_en_in_rst", 8'(bus.mem_w_en), 8'h01);
    step;
    check_reset_outputs("rg");
    reset = 1'b0;
    bus.ext_req = 1'b0;
    exp_cpu_r = 8'h00; exp_ext_r = 8'h00;
    step;
    check("rg_no_ext_ack", 8'(bus.ext_ack), 8'h00);
    check("rg_mem_40", mem[8'h40], 8'h99);

    // CPU drops req mid-write; access still completes
    bus.cpu_req = 1'b1; bus.cpu_w_en = 1'b1; bus.cpu_addr = 8'h05; bus.cpu_w_data = 8'h77;
    sb.push_back({1'b0, exp_cpu_r});
    step;
    bus.cpu_req = 1'b0;
    check("drop_w_en", 8'(bus.mem_w_en), 8'h01);
    step;
    check("drop_ack", 8'(bus.cpu_ack), 8'h01);
    step;
    check("drop_ack_pulse", 8'(bus.cpu_ack), 8'h00);
    check("drop_mem_05", mem[8'h05], 8'h77);

    step; step;
    check("sb_empty", 8'(sb.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports `clock` and `reset`.
REQ-002 `clock` SHALL be an input, 1 bit wide: the rising-edge clock shared with cpu and data_mem.
REQ-003 `reset` SHALL be an input, 1 bit wide: synchronous, active-high.
REQ-004 `cpu_req` SHALL be an input, 1 bit wide: CPU data access request, held until `cpu_ack`.
REQ-005 `cpu_w_en` SHALL be an input, 1 bit wide: 1 = write, 0 = read.
REQ-006 `cpu_addr` and `cpu_w_data` SHALL be inputs, 8 bits wide each: CPU address and write data.
REQ-007 `cpu_r_data` SHALL be an output, 8 bits wide: registered read data returned to the CPU.
REQ-008 `cpu_ack` SHALL be an output, 1 bit wide: one-cycle completion pulse to the CPU.
REQ-009 `cpu_stall` SHALL be an output, 1 bit wide: pipeline hold for the CPU.
REQ-010 `ext_req`, `ext_w_en`, `ext_addr[7:0]`, `ext_w_data[7:0]` SHALL be inputs: the second requester (loader/IO), with the same meanings as the CPU port.
REQ-011 `ext_r_data[7:0]` and `ext_ack` SHALL be outputs: read data and completion pulse for the second requester.
REQ-012 `mem_addr[7:0]`, `mem_w_data[7:0]` and `mem_w_en` SHALL be outputs that drive data_mem.
REQ-013 `mem_r_data[7:0]` SHALL be an input: the combinational read data from data_mem.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, GRANT_CPU, GRANT_EXT, ACK_CPU, ACK_EXT.
REQ-015 In IDLE, if exactly one request is high, the FSM SHALL go to that port's GRANT state on the next edge.
REQ-016 In IDLE with both requests high, the FSM SHALL grant the port that is not `last_grant` (round-robin).
REQ-017 On the IDLE->GRANT edge, the block SHALL latch the winner's addr, w_data and w_en, and set `last_grant` to the winner.
REQ-018 In a GRANT state, `mem_addr` and `mem_w_data` SHALL equal the latched values, and `mem_w_en` SHALL equal the latched w_en, for exactly that one cycle.
REQ-019 Outside the GRANT states, `mem_w_en` SHALL be 0, and `mem_addr`/`mem_w_data` SHALL hold their last latched values.
REQ-020 On the GRANT_x->ACK_x edge, the block SHALL capture `mem_r_data` into `x_r_data` for reads; on writes, `x_r_data` SHALL be unchanged.
REQ-021 `x_ack` SHALL be 1 only in ACK_x, as a one-cycle pulse.
REQ-022 ACK_x SHALL go to IDLE unconditionally.
REQ-023 Latency SHALL be: request seen in IDLE at cycle N gives GRANT at N+1 and ack at N+2; back-to-back access from one port SHALL be one access per 3 cycles.
REQ-024 A requester SHALL deassert req in its ack cycle; if req is still high in IDLE after ack, it SHALL be treated as a new request.
REQ-025 A request dropped before ack is a protocol violation; the latched access SHALL still complete, including the write, and the ack SHALL still be issued.
REQ-026 A request arriving while the FSM is not in IDLE SHALL wait; no request SHALL be lost while held high.
REQ-027 Under continuous contention, grants SHALL alternate CPU, EXT, CPU, ...; no port SHALL wait more than 6 cycles from IDLE.
REQ-028 `cpu_stall` SHALL equal `cpu_req & ~cpu_ack` (combinational).
REQ-029 `x_r_data` SHALL hold its value until the next read completes on that same port.

Reset
REQ-030 When `reset` is sampled high, the FSM SHALL go to IDLE on that edge, from any state.
REQ-031 On reset, the block SHALL set `last_grant` = EXT, so the CPU wins the first tie.
REQ-032 On reset, `cpu_ack`, `ext_ack`, `mem_w_en` SHALL be 0, and `cpu_r_data`, `ext_r_data`, `mem_addr`, `mem_w_data` SHALL be 0x00.
REQ-033 If reset is asserted during a GRANT state, the write in progress that cycle SHALL still be presented (combinational), but no ack SHALL follow.
REQ-034 The first request after reset is released SHALL be arbitrated from IDLE normally.

Verification
REQ-035 Single CPU write: cpu_req=1, w_en=1, addr=0x10, w_data=0xA5 -> mem_w_en=1 with mem_addr=0x10 at N+1; cpu_ack=1 at N+2; cpu_stall=1 at N and N+1.
REQ-036 Single ext read: mem[0x20]=0x3C, ext_req at N -> ext_ack at N+2, ext_r_data=0x3C; cpu_r_data unchanged.
REQ-037 Simultaneous requests right after reset: CPU (addr 0x01) is granted first with ack at N+2; EXT (addr 0x02) is granted at N+4 with ack at N+5.
REQ-038 Both requesters re-requesting continuously for 12 cycles -> strictly alternating acks, 4 total, with no port starved.
REQ-039 Reset asserted in GRANT_EXT -> no ext_ack, FSM in IDLE next cycle, all outputs at reset values.
REQ-040 CPU req dropped in GRANT_CPU during a write of 0x77 to 0x05 -> mem[0x05]=0x77, and cpu_ack still pulses once.
